// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control encodings,
// datapath width and the sequencer state type.
package alu_share_arbiter_pkg;

    localparam int ALU_CTRL_W = 4;
    localparam int ALU_DATA_W = 32;
    // Requester index space is always sized for the largest legal NUM_REQ.
    localparam int MAX_REQ    = 4;
    localparam int IDX_W      = 2;

    // 4'b0101 and 4'b1111 are intentionally unassigned; the ALU returns 0 for them.
    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ADDU = 4'b1000,
        ALU_SUBU = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Fixed 32-bit combinational ALU. Shift amount is the full BusA, the shifted
// operand is BusB; LUI moves BusB[15:0] into the upper half.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    output logic [ALU_DATA_W-1:0] BusW,
    output logic                  Zero,
    input  logic [ALU_DATA_W-1:0] BusA,
    input  logic [ALU_DATA_W-1:0] BusB,
    input  logic [ALU_CTRL_W-1:0] ALUCtrl
);

    always_comb begin
        BusW = '0;
        case (ALUCtrl)
            ALU_AND:  BusW = BusA & BusB;
            ALU_OR:   BusW = BusA | BusB;
            ALU_ADD,
            ALU_ADDU: BusW = BusA + BusB;
            ALU_SUB,
            ALU_SUBU: BusW = BusA - BusB;
            ALU_SLL:  BusW = BusB << BusA;
            ALU_SRL:  BusW = BusB >> BusA;
            ALU_SRA:  BusW = $unsigned($signed(BusB) >>> BusA);
            ALU_SLT:  BusW = {31'b0, $signed(BusA) < $signed(BusB)};
            ALU_SLTU: BusW = {31'b0, BusA < BusB};
            ALU_XOR:  BusW = BusA ^ BusB;
            ALU_NOR:  BusW = ~(BusA | BusB);
            ALU_LUI:  BusW = {BusB[15:0], 16'h0000};
            default:  BusW = '0;
        endcase
    end

    assign Zero = (BusW == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters; one operation in
// flight, result held in registers until the owning requester accepts it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                         CLK,
    input  logic                         Resetb,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [ALU_CTRL_W*NUM_REQ-1:0] req_ctrl,
    input  logic [DATA_W*NUM_REQ-1:0]    req_a,
    input  logic [DATA_W*NUM_REQ-1:0]    req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_zero,
    output logic                         busy
);

    arb_state_e              state_reg, state_next;
    logic [IDX_W-1:0]        last_grant_reg, grant_idx;
    logic                    grant_found, grant_fire;
    logic [2:0]              cand_sum;
    logic [ALU_CTRL_W-1:0]   ctrl_reg;
    logic [DATA_W-1:0]       a_reg, b_reg, data_reg;
    logic                    zero_reg;
    logic [MAX_REQ-1:0]      valid_ext, rsp_ready_ext;
    logic [ALU_CTRL_W-1:0]   ctrl_arr [MAX_REQ];
    logic [DATA_W-1:0]       a_arr [MAX_REQ];
    logic [DATA_W-1:0]       b_arr [MAX_REQ];
    logic [ALU_DATA_W-1:0]   alu_w;
    logic                    alu_zero;

    // Pad per-requester views to MAX_REQ so a 2-bit index always fits exactly.
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_req
        if (gi < NUM_REQ) begin : g_live
            assign valid_ext[gi]     = req_valid[gi];
            assign rsp_ready_ext[gi] = rsp_ready[gi];
            assign ctrl_arr[gi]      = req_ctrl[gi*ALU_CTRL_W +: ALU_CTRL_W];
            assign a_arr[gi]         = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]         = req_b[gi*DATA_W +: DATA_W];
            assign req_ready[gi]     = grant_fire && (grant_idx == IDX_W'(gi));
            assign rsp_valid[gi]     = (state_reg == ST_RESP) && (last_grant_reg == IDX_W'(gi));
        end else begin : g_pad
            assign valid_ext[gi]     = 1'b0;
            assign rsp_ready_ext[gi] = 1'b0;
            assign ctrl_arr[gi]      = '0;
            assign a_arr[gi]         = '0;
            assign b_arr[gi]         = '0;
        end
    end

    // Search last_grant+1, +2, ... wrapping, first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, last_grant_reg} + 3'(k);
            if (cand_sum >= 3'(NUM_REQ))
                cand_sum = cand_sum - 3'(NUM_REQ);
            if (!grant_found && valid_ext[cand_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next = ST_EXEC;
                    // Gated so req_ready reads 0 while reset is asserted.
                    grant_fire = Resetb;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_ext[last_grant_reg])
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // last_grant_reg doubles as the owner of the op in flight.
    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            ctrl_reg       <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            data_reg       <= '0;
            zero_reg       <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && grant_found) begin
                last_grant_reg <= grant_idx;
                ctrl_reg       <= ctrl_arr[grant_idx];
                a_reg          <= a_arr[grant_idx];
                b_reg          <= b_arr[grant_idx];
            end
            if (state_reg == ST_EXEC) begin
                data_reg <= alu_w;
                zero_reg <= alu_zero;
            end
        end
    end

    alu_share_arbiter_alu u_alu (
        .BusW    (alu_w),
        .Zero    (alu_zero),
        .BusA    (a_reg),
        .BusB    (b_reg),
        .ALUCtrl (ctrl_reg)
    );

    assign rsp_data = data_reg;
    assign rsp_zero = zero_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed cases then random traffic,
// expected responses come from a behavioural model of arbitration and ALU ops.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N = 3;

    logic            CLK = 1'b0;
    logic            Resetb = 1'b0;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [4*N-1:0]  req_ctrl;
    logic [32*N-1:0] req_a, req_b;
    logic [31:0]     rsp_data;
    logic            rsp_zero, busy;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(32)) dut (
        .CLK       (CLK),
        .Resetb    (Resetb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          pend[N];
    logic [3:0]  op_c[N];
    logic [31:0] op_a[N], op_b[N];
    int          remaining[N];
    int          prob = 100;
    int          rr_mode = 0;
    int          m_phase = 0;
    int          m_last = N - 1;
    int          m_owner = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference ALU written from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010, 4'b1000: begin wide = {32'b0, a} + {32'b0, b}; return wide[31:0]; end
            4'b0110, 4'b1001: begin wide = {32'b0, a} + {32'b0, ~b} + 64'd1; return wide[31:0]; end
            4'b0011: return (a >= 32) ? 32'd0 : (b << a[4:0]);
            4'b0100: return (a >= 32) ? 32'd0 : (b >> a[4:0]);
            4'b1101: return (a >= 32) ? {32{b[31]}} : $unsigned($signed(b) >>> a[4:0]);
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: return (a < b) ? 32'd1 : 32'd0;
            4'b1010: return a ^ b;
            4'b1100: return ~(a | b);
            4'b1110: return b * 32'h10000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1'b1;
        op_c[i] = c;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic model_reset();
        sb.delete();
        m_phase = 0;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i]      = 1'b0;
            remaining[i] = 0;
        end
    endtask

    // One cycle of stimulus plus model checks; called right at a falling edge.
    task automatic body();
        int g;
        int c;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && remaining[i] > 0 && $urandom_range(99) < prob) begin
                issue(i, 4'($urandom_range(15)),
                      ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom, $urandom);
                remaining[i]--;
            end
            req_valid[i]      = pend[i];
            req_ctrl[4*i +: 4] = op_c[i];
            req_a[32*i +: 32] = op_a[i];
            req_b[32*i +: 32] = op_b[i];
        end
        case (rr_mode)
            0:       rsp_ready = '1;
            1:       rsp_ready = N'($urandom);
            default: rsp_ready = '0;
        endcase
        #1;
        case (m_phase)
            0: begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (g < 0 && pend[c]) g = c;
                end
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                if (g >= 0) begin
                    chk("grant", 32'(req_ready), 32'd1 << g);
                    e.owner = g;
                    e.data  = ref_alu(op_c[g], op_a[g], op_b[g]);
                    e.zero  = (e.data == 32'd0);
                    sb.push_back(e);
                    m_last   = g;
                    m_owner  = g;
                    pend[g]  = 1'b0;
                    m_phase  = 1;
                end else begin
                    chk("no_grant", 32'(req_ready), 32'd0);
                end
            end
            1: begin
                chk("exec_ready", 32'(req_ready), 32'd0);
                chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("exec_busy", 32'(busy), 32'd1);
                m_phase = 2;
            end
            default: begin
                chk("resp_ready", 32'(req_ready), 32'd0);
                chk("resp_valid", 32'(rsp_valid), 32'd1 << m_owner);
                chk("resp_busy", 32'(busy), 32'd1);
                if (rsp_ready[m_owner]) m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        @(negedge CLK);
        body();
    endtask

    task automatic drain();
        int k;
        bit busy_left;
        k = 0;
        busy_left = 1'b1;
        while (busy_left && k < 3000) begin
            step();
            k++;
            busy_left = (m_phase != 0) || (sb.size() != 0);
            for (int i = 0; i < N; i++)
                if (pend[i] || remaining[i] > 0) busy_left = 1'b1;
        end
        chk("drain_done", 32'(busy_left), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Resetb = 1'b0;
        model_reset();
        @(negedge CLK);
        Resetb = 1'b1;
        body();
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb[0];
                    chk("rsp_owner", 32'(rsp_valid), 32'd1 << e.owner);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    if ((rsp_valid & rsp_ready) != '0) begin
                        void'(sb.pop_front());
                        $display("rsp owner=%0d data=%h zero=%b", e.owner, rsp_data, rsp_zero);
                    end
                end
            end
        end
    end

    logic [3:0]  t6_c[5];
    logic [31:0] t6_a[5], t6_b[5];

    initial begin
        req_valid = '1;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            op_c[i] = '0; op_a[i] = '0; op_b[i] = '0;
        end

        // Reset state, with requests present to show req_ready stays low.
        @(negedge CLK);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        @(negedge CLK);
        Resetb = 1'b1;
        body();

        // Single ADD on requester 0.
        rr_mode = 0;
        issue(0, ALU_ADD, 32'd5, 32'd7);
        drain();

        // Two simultaneous requests right after reset: requester 0 goes first.
        do_reset();
        issue(0, ALU_SUB, 32'd9, 32'd9);
        issue(1, ALU_SLL, 32'd4, 32'd1);
        drain();

        // Both continuously valid, three ops each.
        remaining[0] = 3;
        remaining[1] = 3;
        prob = 100;
        drain();

        // Stall in the response phase with another requester waiting.
        issue(0, ALU_XOR, $urandom, $urandom);
        issue(1, ALU_OR, $urandom, $urandom);
        step();
        step();
        rr_mode = 2;
        repeat (6) step();
        rr_mode = 0;
        drain();

        // Reset while an op is executing: it must never be answered.
        issue(0, ALU_ADD, 32'd1, 32'd2);
        step();
        @(negedge CLK);
        Resetb = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", rsp_data, 32'd0);
        chk("mid_rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge CLK);
        Resetb = 1'b1;
        issue(1, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        issue(0, ALU_NOR, 32'h0, 32'h0);
        body();
        drain();

        // Boundary operations.
        t6_c = '{ALU_SLT, ALU_SLTU, ALU_SRA, ALU_LUI, 4'b1111};
        t6_a = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'h1234_5678};
        t6_b = '{32'd1, 32'd1, 32'h8000_0000, 32'h0000_1234, 32'h9ABC_DEF0};
        for (int i = 0; i < 5; i++) begin
            issue(0, t6_c[i], t6_a[i], t6_b[i]);
            drain();
        end
        issue(1, ALU_SRA, 32'd40, 32'h8000_0001);
        drain();
        issue(2, ALU_SLL, 32'd32, 32'hFFFF_FFFF);
        drain();

        // Random traffic on all requesters with random response back-pressure.
        prob = 30;
        rr_mode = 1;
        for (int i = 0; i < N; i++) remaining[i] = 40;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
